// File: rtl/sink_ahb_master.sv
// Sink-side AHB-Lite master: one SINGLE NONSEQ transfer per accepted request.
// Optional error counter/address ports enabled by SINK_AHB_ERR_CNT_EN.
`timescale 1ns/1ps
module sink_ahb_master #(
    parameter int              ADDR_WIDTH = 32,
    parameter int              DATA_WIDTH = 32,
    parameter logic [2:0]      HSIZE_VAL  = 3'b010,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  i_clk_sink,
    input  logic                  i_rstn_sink,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic [1:0]            o_htrans,
    output logic                  o_hwrite,
    output logic [2:0]            o_hsize,
    output logic [2:0]            o_hburst,
    output logic [3:0]            o_hprot,
    output logic [DATA_WIDTH-1:0] o_hwdata,
    input  logic                  i_hready,
    input  logic                  i_hresp,
    input  logic [DATA_WIDTH-1:0] i_hrdata
`ifdef SINK_AHB_ERR_CNT_EN
    ,
    output logic [7:0]            o_err_cnt,
    output logic [ADDR_WIDTH-1:0] o_err_addr
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t state, state_nxt;

    logic                  accept;
    logic                  done;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // o_ready must not depend on i_valid: upstream FIFO read enable uses it.
    assign o_ready = (state == IDLE) || ((state == DATA) && i_hready);
    assign accept  = i_valid && o_ready;
    assign done    = (state == DATA) && i_hready;

    assign o_busy   = (state != IDLE);
    assign o_haddr  = addr_q;
    assign o_hwrite = wr_q;
    assign o_hwdata = wdata_q;
    assign o_hsize  = HSIZE_VAL;
    assign o_hburst = 3'b000;
    assign o_hprot  = 4'b0011;

    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_htrans  = 2'b00;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = ADDR;
            end
            ADDR: begin
                o_htrans = 2'b10;
                if (i_hready) state_nxt = DATA;
            end
            DATA: begin
                if (i_hready) state_nxt = accept ? ADDR : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= i_addr;
            wr_q    <= i_rd0_wr1;
            wdata_q <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_rd_valid <= done && !wr_q;
            if (done && !wr_q) begin
                o_rd_data <= i_hresp ? ERR_DATA : i_hrdata;
            end
        end
    end

`ifdef SINK_AHB_ERR_CNT_EN
    always_ff @(posedge i_clk_sink or negedge i_rstn_sink) begin
        if (!i_rstn_sink) begin
            o_err_cnt  <= 8'h00;
            o_err_addr <= '0;
        end else if (done && i_hresp) begin
            if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'h01;
            o_err_addr <= addr_q;
        end
    end
`endif

endmodule

// File: tb/tb_sink_ahb_master.sv
// Bench for sink_ahb_master: directed protocol steps, then random traffic
// against a memory-backed AHB slave model and a request/response scoreboard.
`timescale 1ns/1ps
module tb_sink_ahb_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_valid, i_rd0_wr1;
    logic [31:0] i_addr, i_wr_data;
    logic        o_ready, o_rd_valid, o_busy, o_hwrite;
    logic [31:0] o_rd_data, o_haddr, o_hwdata;
    logic [1:0]  o_htrans;
    logic [2:0]  o_hsize, o_hburst;
    logic [3:0]  o_hprot;
    logic        hready, hresp;
    logic [31:0] hrdata;
`ifdef SINK_AHB_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic [31:0] err_addr;
`endif

    always #5 clk = ~clk;

    sink_ahb_master dut (
        .i_clk_sink (clk),
        .i_rstn_sink(rstn),
        .i_valid    (i_valid),
        .i_rd0_wr1  (i_rd0_wr1),
        .i_addr     (i_addr),
        .i_wr_data  (i_wr_data),
        .o_ready    (o_ready),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_busy     (o_busy),
        .o_haddr    (o_haddr),
        .o_htrans   (o_htrans),
        .o_hwrite   (o_hwrite),
        .o_hsize    (o_hsize),
        .o_hburst   (o_hburst),
        .o_hprot    (o_hprot),
        .o_hwdata   (o_hwdata),
        .i_hready   (hready),
        .i_hresp    (hresp),
        .i_hrdata   (hrdata)
`ifdef SINK_AHB_ERR_CNT_EN
        ,
        .o_err_cnt  (err_cnt),
        .o_err_addr (err_addr)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        w;
        logic [31:0] d;
    } req_t;

    int          tests = 0;
    int          failed = 0;
    req_t        req_q[$];
    logic [31:0] exp_rsp[$];
    logic [31:0] mem[16];
    bit          cfg_rand = 0;
    int          cfg_waits = 0;
    bit          cfg_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AHB slave model: wait states, two-cycle ERROR response, memory
    initial begin : slave
        bit          dphase;
        int          dcyc, dlen;
        bit          d_err, comp, a_seen;
        req_t        d;
        hready = 1'b1;
        hresp  = 1'b0;
        hrdata = '0;
        dphase = 0;
        dcyc   = 0;
        dlen   = 1;
        d_err  = 0;
        d      = '{32'h0, 1'b0, 32'h0};
        forever begin
            @(negedge clk);
            if (dphase) begin
                hready = (dcyc == dlen - 1);
                hresp  = d_err && (dcyc >= dlen - 2);
                hrdata = (hready && !d_err) ? mem[d.addr[5:2]] : $urandom;
            end else begin
                hready = cfg_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
                hresp  = 1'b0;
                hrdata = $urandom;
            end
            #3;
            a_seen = rstn && (o_htrans == 2'b10);
            comp   = rstn && dphase && hready;
            if (rstn && dphase && d.w) chk("hwdata", o_hwdata, d.d);
            if (comp) begin
                if (d.w) begin
                    if (!d_err) mem[d.addr[5:2]] = d.d;
                end else begin
                    exp_rsp.push_back(d_err ? 32'hDEAD_BEEF : mem[d.addr[5:2]]);
                end
            end
            @(posedge clk);
            if (!rstn || comp) dphase = 0;
            else if (dphase) dcyc++;
            if (rstn && a_seen && hready) begin
                chk("xfer_expected", 32'(req_q.size() != 0), 32'd1);
                if (req_q.size() != 0) begin
                    d = req_q.pop_front();
                    chk("haddr", o_haddr, d.addr);
                    chk("hwrite", 32'(o_hwrite), 32'(d.w));
                    dphase = 1;
                    dcyc   = 0;
                    if (cfg_rand) begin
                        d_err = ($urandom_range(0, 4) == 0);
                        dlen  = $urandom_range(0, 2) + int'(d_err) + 1;
                    end else begin
                        d_err = cfg_err;
                        dlen  = cfg_waits + int'(cfg_err) + 1;
                    end
                end
            end
        end
    end

    initial begin : rsp_mon
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rstn && o_rd_valid) begin
                chk("rsp_expected", 32'(exp_rsp.size() != 0), 32'd1);
                if (exp_rsp.size() != 0) begin
                    e = exp_rsp.pop_front();
                    chk("rd_data", o_rd_data, e);
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int waited);
        waited = 0;
        @(negedge clk);
        #1;
        while (!o_ready && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("issue_ready", 32'(o_ready), 32'd1);
        i_valid   = 1'b1;
        i_rd0_wr1 = w;
        i_addr    = a;
        i_wr_data = d;
        req_q.push_back('{a, w, d});
        @(negedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((req_q.size() != 0 || exp_rsp.size() != 0 || o_busy)
               && n < 300) begin
            @(negedge clk);
            #5;
            n++;
        end
        chk("idle_reqs", 32'(req_q.size()), 32'd0);
        chk("idle_rsps", 32'(exp_rsp.size()), 32'd0);
        chk("idle_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic set_slave(input int waits, input bit err);
        cfg_rand  = 0;
        cfg_waits = waits;
        cfg_err   = err;
    endtask

    initial begin : main
        int          w;
        int          acc, cyc;
        logic [31:0] last_a;
        for (int i = 0; i < 16; i++) mem[i] = 32'h5A00_0000 + 32'(i);
        mem[4]    = 32'hA5A5_0001;
        rstn      = 1'b0;
        i_valid   = 1'b0;
        i_rd0_wr1 = 1'b0;
        i_addr    = '0;
        i_wr_data = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_htrans", 32'(o_htrans), 32'd0);
        chk("rst_haddr", o_haddr, 32'd0);
        chk("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("rst_rd_data", o_rd_data, 32'd0);
        chk("rst_hwdata", o_hwdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_ready", 32'(o_ready), 32'd1);
        chk("rel_busy", 32'(o_busy), 32'd0);
        chk("hsize", 32'(o_hsize), 32'd2);
        chk("hburst", 32'(o_hburst), 32'd0);
        chk("hprot", 32'(o_hprot), 32'd3);

        set_slave(0, 0);
        issue(1'b0, 32'h10, 32'h0, w);
        chk("rd_t1_htrans", 32'(o_htrans), 32'd2);
        chk("rd_t1_haddr", o_haddr, 32'h10);
        chk("rd_t1_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("rd_t2_htrans", 32'(o_htrans), 32'd0);
        chk("rd_t2_busy", 32'(o_busy), 32'd1);
        chk("rd_t2_valid", 32'(o_rd_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("rd_t3_valid", 32'(o_rd_valid), 32'd1);
        chk("rd_t3_data", o_rd_data, 32'hA5A5_0001);
        @(negedge clk);
        #1;
        chk("rd_t4_valid", 32'(o_rd_valid), 32'd0);
        wait_idle();

        set_slave(0, 1);
        issue(1'b0, 32'h30, 32'h0, w);
        @(negedge clk);
        #1;
        chk("err_stall_ready", 32'(o_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("err_done_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        #1;
        chk("err_rd_valid", 32'(o_rd_valid), 32'd1);
        chk("err_rd_data", o_rd_data, 32'hDEAD_BEEF);
`ifdef SINK_AHB_ERR_CNT_EN
        chk("err_cnt_1", 32'(err_cnt), 32'd1);
        chk("err_addr_1", err_addr, 32'h30);
`endif
        wait_idle();

        set_slave(3, 0);
        issue(1'b1, 32'h20, 32'h1234_5678, w);
        chk("wr_addr_ready", 32'(o_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("wr_hwdata", o_hwdata, 32'h1234_5678);
            chk("wr_ready", 32'(o_ready), 32'(k == 3));
            chk("wr_no_rsp", 32'(o_rd_valid), 32'd0);
        end
        @(negedge clk);
        #1;
        chk("wr_no_rsp_after", 32'(o_rd_valid), 32'd0);
        wait_idle();

        set_slave(0, 0);
        issue(1'b1, 32'h24, 32'hCAFE_0001, w);
        issue(1'b0, 32'h24, 32'h0, w);
        chk("b2b_no_wait", 32'(w), 32'd0);
        chk("b2b_htrans", 32'(o_htrans), 32'd2);
        chk("b2b_haddr", o_haddr, 32'h24);
        chk("b2b_hwrite", 32'(o_hwrite), 32'd0);
        wait_idle();

        set_slave(2, 0);
        issue(1'b0, 32'h08, 32'h0, w);
        chk("ign_ready", 32'(o_ready), 32'd0);
        i_valid   = 1'b1;
        i_rd0_wr1 = 1'b1;
        i_addr    = 32'h3C;
        i_wr_data = 32'hBAD0_BAD0;
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        wait_idle();

        set_slave(3, 0);
        issue(1'b0, 32'h14, 32'h0, w);
        @(negedge clk);
        #1;
        chk("rstm_busy", 32'(o_busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rstm_htrans", 32'(o_htrans), 32'd0);
        chk("rstm_haddr", o_haddr, 32'd0);
        chk("rstm_hwrite", 32'(o_hwrite), 32'd0);
        chk("rstm_hwdata", o_hwdata, 32'd0);
        chk("rstm_rd_valid", 32'(o_rd_valid), 32'd0);
        chk("rstm_busy0", 32'(o_busy), 32'd0);
        @(negedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("rstm_no_rsp", 32'(o_rd_valid), 32'd0);
            chk("rstm_ready", 32'(o_ready), 32'd1);
        end
        wait_idle();

`ifdef SINK_AHB_ERR_CNT_EN
        set_slave(0, 1);
        last_a = '0;
        for (int i = 0; i < 260; i++) begin
            last_a = {26'd0, 4'($urandom), 2'b00};
            issue(1'b1, last_a, $urandom, w);
        end
        wait_idle();
        chk("sat_cnt", 32'(err_cnt), 32'hFF);
        chk("sat_addr", err_addr, last_a);
`endif

        cfg_rand = 1;
        acc      = 0;
        cyc      = 0;
        while (acc < 300 && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
            i_valid   = ($urandom_range(0, 2) != 0);
            i_rd0_wr1 = 1'($urandom);
            i_addr    = {26'd0, 4'($urandom), 2'b00};
            i_wr_data = $urandom;
            if (i_valid && o_ready) begin
                req_q.push_back('{i_addr, i_rd0_wr1, i_wr_data});
                acc++;
            end
        end
        @(negedge clk);
        #1;
        i_valid = 1'b0;
        chk("rand_accepted", 32'(acc), 32'd300);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
